// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences PC, fetches one word per instruction over a valid handshake, splits IR into fields.
// 3+ cycles per instruction (FETCH, WAIT until imem_valid, ISSUE held while stall); HALTED is sticky until rst.
module fetch_unit #(
    parameter int                PC_W     = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_valid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 stall,
    input  logic                 halt,
    output logic                 instr_valid,
    output logic [3:0]           opcode,
    output logic [3:0]           rd,
    output logic [3:0]           rs1,
    output logic [3:0]           rs2,
    output logic [7:0]           imm,
    output logic [PC_W-1:0]      pc_out,
    output logic                 halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]         state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            pc_out <= RESET_PC;
        end else begin
            case (state)
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        ir     <= imem_rdata;
                        pc_out <= pc;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // stall outranks halt; halt is looked at again on every ISSUE cycle
                    if (!stall) begin
                        if (halt) begin
                            state <= S_HALTED;
                        end else begin
                            pc    <= pc + PC_W'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end

    // Reset forces state to FETCH asynchronously, so imem_req is high while rst is held.
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALTED);

    assign opcode = ir[15:12];
    assign rd     = ir[11:8];
    assign rs1    = ir[7:4];
    assign rs2    = ir[3:0];
    assign imm    = {{4{ir[3]}}, ir[3:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit; a transaction-level scoreboard predicts fetch address, issued fields and halt behaviour.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        halt;
    logic        instr_valid;
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [7:0]  imm;
    logic [7:0]  pc_out;
    logic        halted;

    int n_chk  = 0;
    int n_pass = 0;
    int m_pc   = 0;

    fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .halt(halt),
        .instr_valid(instr_valid),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected decode of an instruction word, computed arithmetically from the word itself.
    task automatic check_issue(input logic [15:0] word);
        int w, low, exp_imm;
        w   = int'(word);
        low = w % 16;
        exp_imm = (low >= 8) ? (low + 240) : low;
        chk("instr_valid", 32'(instr_valid), 1);
        chk("opcode", 32'(opcode), 32'(w / 4096));
        chk("rd",     32'(rd),     32'((w / 256) % 16));
        chk("rs1",    32'(rs1),    32'((w / 16) % 16));
        chk("rs2",    32'(rs2),    32'(low));
        chk("imm",    32'(imm),    32'(exp_imm));
        chk("pc_out", 32'(pc_out), 32'(m_pc));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},    32'(imem_req), 1);
        chk({tag, "_addr"},   32'(imem_addr), 0);
        chk({tag, "_ivld"},   32'(instr_valid), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_fields"}, {16'h0, opcode, rd, rs1, rs2}, 0);
        chk({tag, "_imm"},    32'(imm), 0);
        chk({tag, "_pc_out"}, 32'(pc_out), 0);
    endtask

    // One instruction from FETCH: lat extra memory cycles, nstall stall cycles, final halt decision,
    // optional spurious imem_valid pulses in FETCH and ISSUE carrying a garbage word.
    task automatic run_instr(input logic [15:0] word, input int lat, input int nstall,
                             input logic hlt, input logic spur);
        chk("req_fetch",  32'(imem_req), 1);
        chk("addr_fetch", 32'(imem_addr), 32'(m_pc));
        chk("ivld_fetch", 32'(instr_valid), 0);
        imem_valid = spur;
        imem_rdata = ~word;
        tick();
        for (int k = 0; k < lat; k++) begin
            imem_valid = 1'b0;
            chk("req_wait",  32'(imem_req), 0);
            chk("ivld_wait", 32'(instr_valid), 0);
            tick();
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        chk("req_wait",  32'(imem_req), 0);
        chk("ivld_wait", 32'(instr_valid), 0);
        tick();
        imem_valid = spur;
        imem_rdata = ~word;
        for (int s = 0; s <= nstall; s++) begin
            stall = (s < nstall);
            halt  = (s < nstall) ? (hlt | 1'($urandom_range(0, 1))) : hlt;
            check_issue(word);
            chk("req_issue",    32'(imem_req), 0);
            chk("halted_issue", 32'(halted), 0);
            tick();
        end
        stall      = 1'b0;
        halt       = 1'b0;
        imem_valid = 1'b0;
        if (!hlt) m_pc = (m_pc + 1) % 256;
    endtask

    task automatic run_rand();
        run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0,
                  1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        halt       = 1'b0;
        #1;
        check_reset_vals("rst_init");
        tick();
        tick();
        rst = 1'b0;

        // Zero-wait memory, then sign-extension corner cases.
        run_instr(16'h1123, 0, 0, 1'b0, 1'b0);
        run_instr(16'h521F, 0, 0, 1'b0, 1'b0);
        run_instr(16'h5217, 0, 0, 1'b0, 1'b0);

        while (m_pc != 5) run_rand();
        run_instr(16'hA5C9, 4, 2, 1'b0, 1'b1);

        // Reset asserted in the middle of a long WAIT at pc 0x12.
        while (m_pc != 8'h12) run_rand();
        chk("addr_pre_rst", 32'(imem_addr), 32'h12);
        tick();
        tick();
        chk("midwait_req", 32'(imem_req), 0);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        tick();
        rst  = 1'b0;
        m_pc = 0;
        run_instr(16'h0000, 1, 0, 1'b0, 1'b0);

        // PC wrap from 0xFF back to 0x00.
        while (m_pc != 8'hFF) run_rand();
        run_instr(16'h7F3B, 0, 0, 1'b0, 1'b0);
        chk("wrap_addr", 32'(imem_addr), 0);

        // Stall with halt held high for 3 cycles, then halt takes effect.
        run_instr(16'hF000, 1, 3, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            chk("halted",      32'(halted), 1);
            chk("req_halted",  32'(imem_req), 0);
            chk("ivld_halted", 32'(instr_valid), 0);
            chk("addr_halted", 32'(imem_addr), 32'(m_pc));
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = 16'($urandom);
            halt       = 1'($urandom_range(0, 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
